// File: rtl/gigerx_bcnt_pkg.sv
// Shared constants and helpers for the multi-channel byte-count FIFO.
// Optional running-sum output is controlled by GIGERX_BCNT_FIFO_SUM_EN in the top level.
package gigerx_bcnt_pkg;

    localparam int BCNT_WIDTH    = 16;
    localparam int BCNT_DEPTH    = 256;
    localparam int BCNT_PTR      = 8;
    localparam int BCNT_NCH      = 4;
    localparam int BCNT_AFULL_TH = 240;

    // Channel-select width never drops below one bit, even for a single channel.
    function automatic int bcnt_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive, hence one bit wider than a pointer.
    function automatic int usedw_w(input int ptr);
        return ptr + 1;
    endfunction

    localparam int BCNT_CHW = bcnt_clog2(BCNT_NCH);

endpackage

// File: rtl/gigerx_bcnt_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; the array contents are left untouched.
module gigerx_bcnt_sdpram #(
    parameter int WIDTH = 16,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // The read register holds its value whenever no read is accepted.
    always_ff @(posedge clk) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/gigerx_bcnt_fifo_mc.sv
// Multi-channel byte-count FIFO sharing one RAM partitioned as {channel, pointer}.
// Define GIGERX_BCNT_FIFO_SUM_EN to add the per-channel running byte total output bsum.
module gigerx_bcnt_fifo_mc
    import gigerx_bcnt_pkg::*;
#(
    parameter int WIDTH    = BCNT_WIDTH,
    parameter int DEPTH    = BCNT_DEPTH,
    parameter int PTR      = BCNT_PTR,
    parameter int NCH      = BCNT_NCH,
    parameter int CHW      = BCNT_CHW,
    parameter int AFULL_TH = BCNT_AFULL_TH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wrreq,
    input  logic [CHW-1:0]            wrch,
    input  logic [WIDTH-1:0]          data,
    input  logic                      rdreq,
    input  logic [CHW-1:0]            rdch,
    output logic [WIDTH-1:0]          q,
    output logic                      rdvalid,
    output logic [NCH-1:0]            full,
    output logic [NCH-1:0]            afull,
    output logic [NCH-1:0]            empty,
    output logic [NCH*(PTR+1)-1:0]    usedw,
    output logic [NCH-1:0]            ovf_err,
    output logic [NCH-1:0]            udf_err,
    input  logic                      err_clr
`ifdef GIGERX_BCNT_FIFO_SUM_EN
    ,
    output logic [NCH*(WIDTH+PTR)-1:0] bsum
`endif
);

    localparam int UW = usedw_w(PTR);
    localparam int AW = CHW + PTR;
    localparam logic [UW-1:0] FULL_LVL  = UW'(DEPTH);
    localparam logic [UW-1:0] AFULL_LVL = UW'(AFULL_TH);

    logic [PTR-1:0] wptr    [NCH];
    logic [PTR-1:0] rptr    [NCH];
    logic [UW-1:0]  cnt     [NCH];
    logic [UW-1:0]  cnt_nxt [NCH];
    logic [NCH-1:0] wr_hit;
    logic [NCH-1:0] rd_hit;
    logic [NCH-1:0] wr_acc;
    logic [NCH-1:0] rd_acc;
    logic [PTR-1:0] wptr_sel;
    logic [PTR-1:0] rptr_sel;

    // Accept decisions use the registered status, so same-cycle traffic on a channel never unblocks it.
    always_comb begin
        wptr_sel = '0;
        rptr_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            wr_hit[c]  = wrreq && (wrch == CHW'(c));
            rd_hit[c]  = rdreq && (rdch == CHW'(c));
            wr_acc[c]  = wr_hit[c] && !full[c];
            rd_acc[c]  = rd_hit[c] && !empty[c];
            cnt_nxt[c] = cnt[c];
            if (wr_acc[c] && !rd_acc[c]) cnt_nxt[c] = cnt[c] + UW'(1);
            if (rd_acc[c] && !wr_acc[c]) cnt_nxt[c] = cnt[c] - UW'(1);
            if (wrch == CHW'(c)) wptr_sel = wptr[c];
            if (rdch == CHW'(c)) rptr_sel = rptr[c];
        end
    end

    // A fresh error on a channel outranks err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                cnt[c]  <= '0;
            end
            full    <= '0;
            afull   <= '0;
            empty   <= '1;
            ovf_err <= '0;
            udf_err <= '0;
            rdvalid <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_acc[c]) wptr[c] <= wptr[c] + PTR'(1);
                if (rd_acc[c]) rptr[c] <= rptr[c] + PTR'(1);
                cnt[c]   <= cnt_nxt[c];
                full[c]  <= (cnt_nxt[c] == FULL_LVL);
                afull[c] <= (cnt_nxt[c] >= AFULL_LVL);
                empty[c] <= (cnt_nxt[c] == '0);
                if (wr_hit[c] && full[c])   ovf_err[c] <= 1'b1;
                else if (err_clr)           ovf_err[c] <= 1'b0;
                if (rd_hit[c] && empty[c])  udf_err[c] <= 1'b1;
                else if (err_clr)           udf_err[c] <= 1'b0;
            end
            rdvalid <= |rd_acc;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_usedw
        assign usedw[c*UW +: UW] = cnt[c];
    end

    gigerx_bcnt_sdpram #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (|wr_acc),
        .waddr ({wrch, wptr_sel}),
        .wdata (data),
        .re    (|rd_acc),
        .raddr ({rdch, rptr_sel}),
        .rdata (q)
    );

`ifdef GIGERX_BCNT_FIFO_SUM_EN
    localparam int SW = WIDTH + PTR;

    logic [SW-1:0]  sum [NCH];
    logic [CHW-1:0] rdch_d;

    // The dequeued word only appears on q a cycle later, so its subtraction lags by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) sum[c] <= '0;
            rdch_d <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                sum[c] <= sum[c]
                        + (wr_acc[c] ? SW'(data) : SW'(0))
                        - ((rdvalid && (rdch_d == CHW'(c))) ? SW'(q) : SW'(0));
            end
            rdch_d <= rdch;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_bsum
        assign bsum[c*SW +: SW] = sum[c];
    end
`endif

endmodule

// File: tb/tb_gigerx_bcnt_fifo_mc.sv
// Randomized self-checking bench for gigerx_bcnt_fifo_mc against per-channel queue models.
// Checks bsum as well when GIGERX_BCNT_FIFO_SUM_EN is defined.
module tb_gigerx_bcnt_fifo_mc;

    localparam int NCH   = 4;
    localparam int PTR   = 8;
    localparam int W     = 16;
    localparam int DEPTH = 256;
    localparam int AFT   = 240;
    localparam int UW    = PTR + 1;
    localparam int SW    = W + PTR;

    logic              clk;
    logic              reset;
    logic              wrreq;
    logic [1:0]        wrch;
    logic [W-1:0]      data;
    logic              rdreq;
    logic [1:0]        rdch;
    logic [W-1:0]      q;
    logic              rdvalid;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    afull;
    logic [NCH-1:0]    empty;
    logic [NCH*UW-1:0] usedw;
    logic [NCH-1:0]    ovf_err;
    logic [NCH-1:0]    udf_err;
    logic              err_clr;
`ifdef GIGERX_BCNT_FIFO_SUM_EN
    logic [NCH*SW-1:0] bsum;
    longint            expSum [NCH];
    bit                pendValid;
    int                pendCh;
    longint            pendVal;
`endif

    logic [W-1:0] model [NCH][$];
    logic [W-1:0] expQ;
    bit           expValid;
    bit [NCH-1:0] expOvf;
    bit [NCH-1:0] expUdf;
    int           totalCount;
    int           badCount;

    gigerx_bcnt_fifo_mc dut (
        .clk     (clk),
        .reset   (reset),
        .wrreq   (wrreq),
        .wrch    (wrch),
        .data    (data),
        .rdreq   (rdreq),
        .rdch    (rdch),
        .q       (q),
        .rdvalid (rdvalid),
        .full    (full),
        .afull   (afull),
        .empty   (empty),
        .usedw   (usedw),
        .ovf_err (ovf_err),
        .udf_err (udf_err),
        .err_clr (err_clr)
`ifdef GIGERX_BCNT_FIFO_SUM_EN
        ,
        .bsum    (bsum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalCount++;
        if (got !== exp) begin
            badCount++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare every status output against what the queue models imply.
    task automatic checkAll(input string tag);
        logic [NCH*UW-1:0] eUsedw;
        logic [NCH-1:0]    eFull;
        logic [NCH-1:0]    eAfull;
        logic [NCH-1:0]    eEmpty;
        for (int c = 0; c < NCH; c++) begin
            eUsedw[c*UW +: UW] = UW'(model[c].size());
            eFull[c]  = (model[c].size() == DEPTH);
            eAfull[c] = (model[c].size() >= AFT);
            eEmpty[c] = (model[c].size() == 0);
        end
        checkOutput({tag, "_rdvalid"}, 64'(rdvalid), 64'(expValid));
        checkOutput({tag, "_q"},       64'(q),       64'(expQ));
        checkOutput({tag, "_usedw"},   64'(usedw),   64'(eUsedw));
        checkOutput({tag, "_full"},    64'(full),    64'(eFull));
        checkOutput({tag, "_afull"},   64'(afull),   64'(eAfull));
        checkOutput({tag, "_empty"},   64'(empty),   64'(eEmpty));
        checkOutput({tag, "_ovf"},     64'(ovf_err), 64'(expOvf));
        checkOutput({tag, "_udf"},     64'(udf_err), 64'(expUdf));
`ifdef GIGERX_BCNT_FIFO_SUM_EN
        for (int c = 0; c < NCH; c++)
            checkOutput({tag, "_bsum"}, 64'(bsum[c*SW +: SW]), 64'(expSum[c]));
`endif
    endtask

    task automatic applyStimulus(input bit wr, input int wch, input logic [W-1:0] d,
                                 input bit rd, input int rch, input bit clr, input string tag);
        bit wrOk;
        bit rdOk;
        wrreq   = wr;
        wrch    = 2'(wch);
        data    = d;
        rdreq   = rd;
        rdch    = 2'(rch);
        err_clr = clr;
        wrOk = wr && (model[wch].size() < DEPTH);
        rdOk = rd && (model[rch].size() > 0);
        @(posedge clk);
        #1;
        wrreq   = 1'b0;
        rdreq   = 1'b0;
        err_clr = 1'b0;
        if (clr) begin
            expOvf = '0;
            expUdf = '0;
        end
        if (wr && !wrOk) expOvf[wch] = 1'b1;
        if (rd && !rdOk) expUdf[rch] = 1'b1;
`ifdef GIGERX_BCNT_FIFO_SUM_EN
        if (pendValid) expSum[pendCh] -= pendVal;
        pendValid = 1'b0;
`endif
        if (rdOk) begin
            expQ     = model[rch].pop_front();
            expValid = 1'b1;
`ifdef GIGERX_BCNT_FIFO_SUM_EN
            pendValid = 1'b1;
            pendCh    = rch;
            pendVal   = longint'(expQ);
`endif
        end else begin
            expValid = 1'b0;
        end
        if (wrOk) begin
            model[wch].push_back(d);
`ifdef GIGERX_BCNT_FIFO_SUM_EN
            expSum[wch] += longint'(d);
`endif
        end
        checkAll(tag);
    endtask

    task automatic applyReset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        wrreq   = 1'b0;
        rdreq   = 1'b0;
        err_clr = 1'b0;
        for (int c = 0; c < NCH; c++) model[c].delete();
        expQ     = '0;
        expValid = 1'b0;
        expOvf   = '0;
        expUdf   = '0;
`ifdef GIGERX_BCNT_FIFO_SUM_EN
        for (int c = 0; c < NCH; c++) expSum[c] = 0;
        pendValid = 1'b0;
`endif
        checkAll(tag);
    endtask

    initial begin
        totalCount = 0;
        badCount   = 0;
        reset   = 1'b1;
        wrreq   = 1'b0;
        wrch    = '0;
        data    = '0;
        rdreq   = 1'b0;
        rdch    = '0;
        err_clr = 1'b0;
        applyReset("rst");

        $display("[TB] test 1: ordered read-back on ch1");
        applyStimulus(1, 1, 16'd100, 0, 0, 0, "t1_wr");
        applyStimulus(1, 1, 16'd200, 0, 0, 0, "t1_wr");
        applyStimulus(1, 1, 16'd300, 0, 0, 0, "t1_wr");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1, 1, 0, "t1_rd");
        checkOutput("t1_q_last", 64'(q), 64'd300);
        checkOutput("t1_empty1", 64'(empty[1]), 64'd1);

        $display("[TB] test 2: fill ch0 and overflow");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 16'($urandom), 0, 0, 0, "t2_fill");
        applyStimulus(1, 0, 16'hBEEF, 0, 0, 0, "t2_ovf");
        checkOutput("t2_usedw0", 64'(usedw[UW-1:0]), 64'd256);
        checkOutput("t2_ovf0", 64'(ovf_err[0]), 64'd1);

        $display("[TB] test 3: underflow and error clear");
        applyStimulus(0, 0, '0, 1, 2, 0, "t3_udf");
        applyStimulus(0, 0, '0, 0, 0, 1, "t3_clr");
        applyStimulus(0, 0, '0, 1, 2, 1, "t3_clr_udf");
        checkOutput("t3_udf2", 64'(udf_err[2]), 64'd1);

        $display("[TB] test 4: simultaneous write and read on ch3");
        for (int i = 0; i < 10; i++) applyStimulus(1, 3, 16'($urandom), 0, 0, 0, "t4_pre");
        applyStimulus(1, 3, 16'h1234, 1, 3, 0, "t4_wrrd");
        for (int i = 0; i < DEPTH - 10; i++) applyStimulus(1, 3, 16'($urandom), 0, 0, 0, "t4_fill");
        applyStimulus(1, 3, 16'h5678, 1, 3, 0, "t4_full_wrrd");
        checkOutput("t4_usedw3", 64'(usedw[3*UW +: UW]), 64'd255);

        $display("[TB] test 5: random traffic");
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                wrreq = 1'b1;
                rdreq = 1'b1;
                wrch  = 2'($urandom_range(0, 3));
                rdch  = 2'($urandom_range(0, 3));
                applyReset("t5_rst");
            end else begin
                applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 3), 16'($urandom),
                              $urandom_range(0, 99) < 55, $urandom_range(0, 3),
                              $urandom_range(0, 99) < 5, "t5_rand");
            end
        end

`ifdef GIGERX_BCNT_FIFO_SUM_EN
        $display("[TB] test 6: running byte sum");
        applyReset("t6_rst");
        applyStimulus(1, 0, 16'd64, 0, 0, 0, "t6_wr");
        applyStimulus(1, 0, 16'd1518, 0, 0, 0, "t6_wr");
        checkOutput("t6_sum2", 64'(bsum[SW-1:0]), 64'd1582);
        applyStimulus(0, 0, '0, 1, 0, 0, "t6_rd");
        applyStimulus(0, 0, '0, 0, 0, 0, "t6_idle");
        checkOutput("t6_sum1", 64'(bsum[SW-1:0]), 64'd1518);
`endif

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
